// File: rtl/clkgen_rst_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : clkgen_rst_seq
// Brief    : Reset sequencer for clkgen wrappers. Synchronises PLL lock, pad
//            reset and JTAG reset, filters lock, holds all domain resets for
//            a minimum width, then releases NUM_DOMAINS active-low resets in
//            staggered order (domain 0 first). Runs on the main clock.
// Options  : RST_CAUSE_EN - adds cause_clr_i / cause_o sticky reset-cause
//            register {sw, jtag, ext, lock_loss}.
// Revision : 1.0 - initial release
// ============================================================================
module clkgen_rst_seq #(
  parameter int NUM_DOMAINS        = 3,
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_FILTER_CYCLES = 64,
  parameter int MIN_ASSERT_CYCLES  = 16,
  parameter int STAGGER_CYCLES     = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   pll_locked_i,
  input  logic                   ext_rst_ni,
  input  logic                   jtag_srst_ni,
  input  logic                   sw_rst_req_i,
`ifdef RST_CAUSE_EN
  input  logic                   cause_clr_i,
  output logic [3:0]             cause_o,
`endif
  output logic [NUM_DOMAINS-1:0] rst_no,
  output logic                   all_released_o
);

  // Counter sized for the largest terminal count; index sized for domain count
  localparam int C_MAX_AB = (LOCK_FILTER_CYCLES > MIN_ASSERT_CYCLES) ? LOCK_FILTER_CYCLES : MIN_ASSERT_CYCLES;
  localparam int C_MAX    = (C_MAX_AB > STAGGER_CYCLES) ? C_MAX_AB : STAGGER_CYCLES;
  localparam int CW       = $clog2(C_MAX) + 1;
  localparam int IW       = $clog2(NUM_DOMAINS) + 1;

  localparam logic [CW-1:0] C_LOCK_LAST = CW'(LOCK_FILTER_CYCLES - 1);
  localparam logic [CW-1:0] C_HOLD_LAST = CW'(MIN_ASSERT_CYCLES - 1);
  localparam logic [CW-1:0] C_STAG_LAST = CW'(STAGGER_CYCLES - 1);
  localparam logic [IW-1:0] C_IDX_LAST  = IW'(NUM_DOMAINS - 1);

  localparam logic [1:0] C_ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] C_ST_HOLD      = 2'd1;
  localparam logic [1:0] C_ST_RELEASE   = 2'd2;
  localparam logic [1:0] C_ST_RUN       = 2'd3;

  logic [SYNC_STAGES-1:0] r_lock_sync;
  logic [SYNC_STAGES-1:0] r_ext_sync;
  logic [SYNC_STAGES-1:0] r_jtag_sync;
  logic                   w_lock_s;
  logic                   w_ext_n_s;
  logic                   w_jtag_n_s;
  logic                   w_clean;
  logic                   w_req;

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nxt;
  logic [IW-1:0]          r_idx;
  logic [IW-1:0]          w_idx_nxt;

  logic [NUM_DOMAINS-1:0] r_rst_n;
  logic [NUM_DOMAINS-1:0] w_rst_n_nxt;
  logic                   r_all_rel;
  logic                   w_all_rel_nxt;

  // Synchronisers reset to the "asserted" value so reset holds until inputs settle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lock_sync <= '0;
      r_ext_sync  <= '0;
      r_jtag_sync <= '0;
    end else begin
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], pll_locked_i};
      r_ext_sync  <= {r_ext_sync[SYNC_STAGES-2:0],  ext_rst_ni};
      r_jtag_sync <= {r_jtag_sync[SYNC_STAGES-2:0], jtag_srst_ni};
    end
  end

  assign w_lock_s   = r_lock_sync[SYNC_STAGES-1];
  assign w_ext_n_s  = r_ext_sync[SYNC_STAGES-1];
  assign w_jtag_n_s = r_jtag_sync[SYNC_STAGES-1];
  assign w_clean    = w_lock_s & w_ext_n_s & w_jtag_n_s;
  assign w_req      = ~w_clean | sw_rst_req_i;

  // State, shared cycle counter and release index registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= C_ST_WAIT_LOCK;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state: lock filter, hold timer, stagger timer; req beats any same-cycle advance
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    case (r_state)
      C_ST_WAIT_LOCK: begin
        if (!w_clean) begin
          w_cnt_nxt = '0;
        end else if (r_cnt >= C_LOCK_LAST) begin
          w_state_nxt = C_ST_HOLD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      C_ST_HOLD: begin
        if (w_req) begin
          w_state_nxt = C_ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end else if (r_cnt >= C_HOLD_LAST) begin
          w_state_nxt = (NUM_DOMAINS == 1) ? C_ST_RUN : C_ST_RELEASE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      C_ST_RELEASE: begin
        if (w_req) begin
          w_state_nxt = C_ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end else if (r_cnt >= C_STAG_LAST) begin
          w_cnt_nxt = '0;
          w_idx_nxt = r_idx + IW'(1);
          if ((r_idx + IW'(1)) >= C_IDX_LAST) begin
            w_state_nxt = C_ST_RUN;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      C_ST_RUN: begin
        if (w_req) begin
          w_state_nxt = C_ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = C_ST_WAIT_LOCK;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Outputs derived from next state so they land in flops on the same edge
  always_comb begin
    w_rst_n_nxt   = '0;
    w_all_rel_nxt = 1'b0;
    if ((w_state_nxt == C_ST_RELEASE) || (w_state_nxt == C_ST_RUN)) begin
      for (int k = 0; k < NUM_DOMAINS; k++) begin
        w_rst_n_nxt[k] = (w_idx_nxt >= IW'(k));
      end
      w_all_rel_nxt = (w_state_nxt == C_ST_RUN);
    end
  end

  // Output flops: no combinational path from inputs to outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rst_n   <= '0;
      r_all_rel <= 1'b0;
    end else begin
      r_rst_n   <= w_rst_n_nxt;
      r_all_rel <= w_all_rel_nxt;
    end
  end

  assign rst_no         = r_rst_n;
  assign all_released_o = r_all_rel;

`ifdef RST_CAUSE_EN
  logic       w_capture;
  logic [3:0] r_cause;

  assign w_capture = w_req & (r_state != C_ST_WAIT_LOCK);

  // Sticky cause: OR in active sources on each accepted request; capture beats clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cause <= 4'b0000;
    end else if (w_capture) begin
      r_cause <= r_cause | {sw_rst_req_i, ~w_jtag_n_s, ~w_ext_n_s, ~w_lock_s};
    end else if (cause_clr_i) begin
      r_cause <= 4'b0000;
    end
  end

  assign cause_o = r_cause;
`endif

endmodule
`default_nettype wire
